spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Shares the single byte-level SPI shifter among NUM_REQ independent transaction masters, e.g. the accelerometer init/poll controller, a config writer and a debug port.
- Uses round-robin arbitration.
- A grant is held for a whole chip-select transaction. The bus is re-arbitrated only after the shifter reports chip-select deasserted.
- Sits between the requesters and the SPI shifter. Each requester uses the same begin/send/end/received handshake it would use with the shifter directly.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-requester bus request. Held high for the entire transaction.
- req_begin  in  NUM_REQ  per-requester begin_transmission level.
- req_send_data  in  8*NUM_REQ  per-requester byte to shift; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, registered.
- req_end  out  NUM_REQ  end_transmission pulse, routed to the granted requester only.
- rcv_data  out  8  received byte, broadcast to all requesters.
- spi_begin  out  1  to shifter begin_transmission.
- spi_send_data  out  8  to shifter send_data.
- spi_end  in  1  from shifter end_transmission; one-cycle pulse per byte.
- spi_rcv_data  in  8  from shifter received_data.
- spi_cs  in  1  from shifter chip_select; 1 = bus idle.
- busy  out  1  high in GRANT and DRAIN.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values: gnt=0, spi_begin=0, spi_send_data=0, busy=0, timeout_err=0, rr_ptr=0, state=IDLE. Reset mid-transaction takes effect at the next edge: spi_begin drops and the grant is lost. The shifter then finishes its current byte on its own.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - Select the first index i with req[i]=1, searching upward from rr_ptr and wrapping at NUM_REQ-1.
  - Register gnt[i]=1 and go to GRANT. Latency from req to gnt is 1 cycle.
  - If no req is high, stay in IDLE.
- GRANT (index g):
  - spi_begin = req_begin[g] and spi_send_data = req_send_data[8g+:8]. This is a combinational mux from the registered gnt; no added latency.
  - req_end[g] = spi_end; all other req_end bits are 0. rcv_data = spi_rcv_data at all times.
  - req_begin and req_send_data of non-granted requesters are ignored.
  - When req[g]=0 is sampled: spi_begin is forced to 0 from that cycle, gnt clears at the next edge, and the state moves to DRAIN.
  - Other requests raised during GRANT are queued, not granted.
- DRAIN:
  - spi_begin=0 and gnt=0.
  - Wait until spi_cs=1 is sampled, then set rr_ptr=(g+1) mod NUM_REQ and go to IDLE.
  - If spi_cs is already 1 on entry, the exit happens on the next edge. Minimum turnaround from req drop to the next grant is 3 cycles.
- Fairness: a requester that re-asserts req immediately after release is served only after every other pending requester.
- Simultaneous events: req[g] dropping in the same cycle as spi_end still delivers that req_end pulse to g.
- Outside GRANT, spi_begin and spi_send_data are 0 and req_end is all 0.
- busy = (state != IDLE).

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on grant and on every spi_end pulse, and increments each cycle in GRANT.
  - When it reaches TIMEOUT_CYCLES: force spi_begin=0, clear gnt, pulse timeout_err for 1 cycle, and enter DRAIN as if req[g] had dropped.
  - The requester must drop req before it can be granted again. rr_ptr advances as in a normal release.
- Undefined: no counter; timeout_err is tied to 0. A hung requester holds the bus indefinitely.

Decomposition:
- Package spi_arb_pkg holds: the state encoding (IDLE=0, GRANT=1, DRAIN=2), BYTE_W=8, and the default NUM_REQ and TIMEOUT_CYCLES.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector and rr_ptr. Outputs: one-hot grant and its index.

Test Plan:
- Reset: rst high for 3 cycles while req=2'b11 -> gnt=0, spi_begin=0, busy=0, timeout_err=0. gnt=2'b01 appears 1 cycle after rst falls.
- Single requester:
  - req[0] writes addr 8'h20 then data 8'h4F; the shifter model returns spi_end per byte.
  - spi_send_data shows 8'h20 then 8'h4F.
  - req_end[0] pulses twice; req_end[1] stays 0.
  - gnt[0] clears 1 cycle after req[0] drops.
- Contention and fairness:
  - req=2'b11 from IDLE with rr_ptr=0 -> gnt=2'b01.
  - After release and spi_cs=1 -> gnt=2'b10.
  - req[0] re-asserting during req[1]'s grant is served next.
- Drain hold: req[1] drops while spi_cs=0 for 10 cycles -> no gnt during those 10 cycles. The next grant comes exactly 2 cycles after spi_cs rises.
- Isolation: non-granted requester drives req_begin=1 with data 8'hFF -> spi_send_data still follows the granted requester (8'hE8 read burst). rcv_data follows spi_rcv_data for all 6 bytes.
- Timeout (macro defined, TIMEOUT_CYCLES=16): granted requester holds req with no spi_end for 16 cycles -> timeout_err pulses once, spi_begin=0, state DRAIN. Without the macro, the grant is still held after 100 cycles.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: state encoding, byte width and
// default sizing used by spi_bus_arbiter and rr_pick.
package spi_arb_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int WDOG_W             = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Index width for a requester vector; a single-bit index even for n=1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping at NUM_REQ-1.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               valid
);

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!valid && req[(int'(rr_ptr) + off) % NUM_REQ]) begin
                valid   = 1'b1;
                gnt_idx = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
                gnt[(int'(rr_ptr) + off) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI shifter among NUM_REQ masters;
// grants last a full chip-select transaction. Optional watchdog: SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_begin,
    input  logic [BYTE_W*NUM_REQ-1:0] req_send_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        req_end,
    output logic [BYTE_W-1:0]         rcv_data,
    output logic                      spi_begin,
    output logic [BYTE_W-1:0]         spi_send_data,
    input  logic                      spi_end,
    input  logic [BYTE_W-1:0]         spi_rcv_data,
    input  logic                      spi_cs,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] req_eligible;
    logic               pick_valid;
    logic               in_grant;
    logic               owner_req;
    logic               wdog_abort;

    assign in_grant  = (state == GRANT);
    assign owner_req = req[gnt_idx];
    assign busy      = (state != IDLE);
    assign rcv_data  = spi_rcv_data;
    assign next_ptr  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_eligible),
        .rr_ptr  (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0]  wdog;
    logic [NUM_REQ-1:0] locked;

    // A timed-out requester stays masked until it has dropped req once.
    assign req_eligible = req & ~locked;
    assign wdog_abort   = in_grant && owner_req && !spi_end &&
                          (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog        <= '0;
            locked      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wdog_abort;
            locked      <= (locked | (wdog_abort ? gnt : '0)) & req;
            if (spi_end || (state == IDLE && pick_valid))
                wdog <= '0;
            else if (in_grant)
                wdog <= wdog + 1'b1;
        end
    end
`else
    assign req_eligible = req;
    assign wdog_abort   = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt     <= pick_gnt;
                        gnt_idx <= pick_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || wdog_abort) begin
                        gnt   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (spi_cs) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Shifter-side mux follows the registered owner; begin is cut the moment
    // the owner lets go of req so no new byte can start during release.
    always_comb begin
        spi_begin     = 1'b0;
        spi_send_data = '0;
        req_end       = '0;
        if (in_grant) begin
            spi_begin        = req_begin[gnt_idx] & owner_req;
            spi_send_data    = req_send_data[int'(gnt_idx)*BYTE_W +: BYTE_W];
            req_end[gnt_idx] = spi_end;
        end
    end

endmodule
